// File: rtl/fft_bfly_sched.sv
// Sequencer for one delay-buffer + butterfly FFT stage: frames of 2*SIZE blocks
// followed by SIZE drain cycles that empty the buffered differences.
module fft_bfly_sched #(
  parameter  int SIZE = 16,
  localparam int CW   = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          din_valid,
  input  logic          din_sop,
  output logic          din_ready,
  output logic          sr_shift,
  output logic          bfly_en,
  output logic          out_sel,
  output logic [CW-1:0] tw_idx,
  output logic          dout_valid,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic          err_sop
);

  typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          xfer;

  assign din_ready = (state != DRAIN);
  assign xfer      = din_valid & din_ready;

  // A sop arriving in BFLY restarts the frame, so that block must not be combined.
  always_comb begin
    sr_shift = 1'b0;
    bfly_en  = 1'b0;
    case (state)
      IDLE:  sr_shift = xfer & din_sop;
      FILL:  sr_shift = xfer;
      BFLY: begin
        sr_shift = xfer;
        bfly_en  = xfer & ~din_sop;
      end
      DRAIN: sr_shift = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      out_sel    <= 1'b0;
      tw_idx     <= '0;
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      err_sop    <= 1'b0;
    end else begin
      out_sel    <= 1'b0;
      tw_idx     <= '0;
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      err_sop    <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (din_sop) begin
              state <= FILL;
              cnt   <= ONE;
            end else begin
              err_sop <= 1'b1;
            end
          end
        end
        FILL: begin
          if (xfer) begin
            if (din_sop) begin
              err_sop <= 1'b1;
              cnt     <= ONE;
            end else if (cnt == LAST) begin
              state <= BFLY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        BFLY: begin
          if (xfer) begin
            if (din_sop) begin
              err_sop <= 1'b1;
              state   <= FILL;
              cnt     <= ONE;
            end else begin
              dout_valid <= 1'b1;
              dout_sop   <= (cnt == '0);
              if (cnt == LAST) begin
                state <= DRAIN;
                cnt   <= '0;
              end else begin
                cnt <= cnt + ONE;
              end
            end
          end
        end
        DRAIN: begin
          dout_valid <= 1'b1;
          out_sel    <= 1'b1;
          tw_idx     <= cnt;
          if (cnt == LAST) begin
            dout_eop <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Bench for fft_bfly_sched (SIZE=4): block-count frame model checked every cycle,
// plus directed scenarios with hand-computed beat sequences and counts.
module tb_fft_bfly_sched;

  localparam int SIZE = 4;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          din_valid = 1'b0;
  logic          din_sop = 1'b0;
  logic          din_ready, sr_shift, bfly_en, out_sel;
  logic [CW-1:0] tw_idx;
  logic          dout_valid, dout_sop, dout_eop, err_sop;

  fft_bfly_sched #(.SIZE(SIZE)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_sop(din_sop),
    .din_ready(din_ready), .sr_shift(sr_shift), .bfly_en(bfly_en),
    .out_sel(out_sel), .tw_idx(tw_idx), .dout_valid(dout_valid),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .err_sop(err_sop)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
  endtask

  // Model state: blocks accepted in the current frame (0 = idle), drain index (-1 = none)
  int m_blk = 0;
  int m_drain = -1;
  int p_v = 0, p_sel = 0, p_tw = 0, p_sop = 0, p_eop = 0, p_err = 0;
  int e_ready, e_shift, e_bfly, xfer;
  int n_shift = 0, n_bfly = 0, n_err = 0, n_eop = 0, n_ready_low = 0;
  logic [4:0] beats[$];

  always @(negedge clk) begin
    if (!rstn) begin
      m_blk = 0; m_drain = -1;
      p_v = 0; p_sel = 0; p_tw = 0; p_sop = 0; p_eop = 0; p_err = 0;
      checkOutput("rst_dout_valid", dout_valid, 0);
      checkOutput("rst_err_sop", err_sop, 0);
      checkOutput("rst_tw_idx", tw_idx, 0);
    end else begin
      checkOutput("dout_valid", dout_valid, p_v);
      checkOutput("out_sel", out_sel, p_sel);
      checkOutput("tw_idx", tw_idx, p_tw);
      checkOutput("dout_sop", dout_sop, p_sop);
      checkOutput("dout_eop", dout_eop, p_eop);
      checkOutput("err_sop", err_sop, p_err);
      if (dout_valid) beats.push_back({out_sel, tw_idx, dout_sop, dout_eop});
      if (err_sop) n_err++;
      if (dout_eop) n_eop++;

      p_v = 0; p_sel = 0; p_tw = 0; p_sop = 0; p_eop = 0; p_err = 0;
      e_ready = (m_drain < 0) ? 1 : 0;
      e_shift = 0;
      e_bfly  = 0;
      xfer    = (din_valid && e_ready != 0) ? 1 : 0;
      if (m_drain >= 0) begin
        e_shift = 1;
        p_v = 1; p_sel = 1; p_tw = m_drain; p_eop = (m_drain == SIZE - 1) ? 1 : 0;
        m_drain++;
        if (m_drain == SIZE) m_drain = -1;
      end else if (xfer != 0) begin
        if (din_sop) begin
          e_shift = 1;
          p_err = (m_blk > 0) ? 1 : 0;
          m_blk = 1;
        end else if (m_blk == 0) begin
          p_err = 1;
        end else begin
          e_shift = 1;
          if (m_blk >= SIZE) begin
            e_bfly = 1;
            p_v = 1;
            p_sop = (m_blk == SIZE) ? 1 : 0;
          end
          m_blk++;
          if (m_blk == 2 * SIZE) begin
            m_blk = 0;
            m_drain = 0;
          end
        end
      end
      checkOutput("din_ready", din_ready, e_ready);
      checkOutput("sr_shift", sr_shift, e_shift);
      checkOutput("bfly_en", bfly_en, e_bfly);
      if (sr_shift) n_shift++;
      if (bfly_en) n_bfly++;
      if (!din_ready) n_ready_low++;
    end
  end

  task automatic applyStimulus(input logic v, input logic s);
    din_valid = v;
    din_sop   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic clearCounts();
    n_shift = 0; n_bfly = 0; n_err = 0; n_eop = 0; n_ready_low = 0;
    beats.delete();
  endtask

  // One complete frame of SIZE=4: sums with tw 0, then differences with tw 0..3
  task automatic checkFrameBeats(input string tag, input int base);
    int exp_sel[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int exp_tw[8]  = '{0, 0, 0, 0, 0, 1, 2, 3};
    logic [4:0] b;
    for (int i = 0; i < 8; i++) begin
      if (base + i < beats.size()) begin
        b = beats[base + i];
        checkOutput({tag, "_sel"}, b[4], exp_sel[i]);
        checkOutput({tag, "_tw"}, b[3:2], exp_tw[i]);
        checkOutput({tag, "_sop"}, b[1], (i == 0) ? 1 : 0);
        checkOutput({tag, "_eop"}, b[0], (i == 7) ? 1 : 0);
      end else begin
        checkOutput({tag, "_beat_missing"}, base + i, beats.size());
      end
    end
  endtask

  initial begin
    #1 rstn = 1'b0;
    #21 rstn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_ready", din_ready, 1);
    checkOutput("reset_valid", dout_valid, 0);

    // Test 1: contiguous frame
    clearCounts();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("t1_ready_in_drain", din_ready, 0);
    idleCycles(6);
    checkOutput("t1_beats", beats.size(), 8);
    checkFrameBeats("t1", 0);
    checkOutput("t1_shift_cycles", n_shift, 12);
    checkOutput("t1_bfly_cycles", n_bfly, 4);
    checkOutput("t1_ready_low", n_ready_low, 4);
    checkOutput("t1_err", n_err, 0);

    // Test 2: one-cycle gaps between blocks
    clearCounts();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
    end
    idleCycles(6);
    checkOutput("t2_beats", beats.size(), 8);
    checkFrameBeats("t2", 0);
    checkOutput("t2_bfly_cycles", n_bfly, 4);
    checkOutput("t2_eop", n_eop, 1);

    // Test 3: valid without sop while idle
    clearCounts();
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_err_pulse", err_sop, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t3_err_cleared", err_sop, 0);
    checkOutput("t3_ready", din_ready, 1);
    idleCycles(2);
    checkOutput("t3_shift_cycles", n_shift, 0);
    checkOutput("t3_err_count", n_err, 1);

    // Test 4: sop on block 6 aborts the frame, then the new frame completes
    clearCounts();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("t4_first_sum_beat", dout_valid, 1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t4_err_pulse", err_sop, 1);
    checkOutput("t4_no_beat", dout_valid, 0);
    checkOutput("t4_no_eop", n_eop, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
    idleCycles(6);
    checkOutput("t4_beats", beats.size(), 9);
    checkFrameBeats("t4", 1);
    checkOutput("t4_err_count", n_err, 1);
    checkOutput("t4_eop_count", n_eop, 1);

    // Test 5: back-to-back frames with din_valid held high
    clearCounts();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("t5_ready_after_drain", din_ready, 1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    idleCycles(3);
    checkOutput("t5_ready_low", n_ready_low, 8);
    checkOutput("t5_beats", beats.size(), 16);
    checkFrameBeats("t5a", 0);
    checkFrameBeats("t5b", 8);
    checkOutput("t5_err", n_err, 0);

    // Test 6: asynchronous reset during DRAIN with cnt=2
    clearCounts();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
    idleCycles(2);
    checkOutput("t6_pre_valid", dout_valid, 1);
    checkOutput("t6_pre_tw", tw_idx, 1);
    checkOutput("t6_pre_ready", din_ready, 0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t6_valid", dout_valid, 0);
    checkOutput("t6_sel", out_sel, 0);
    checkOutput("t6_tw", tw_idx, 0);
    checkOutput("t6_ready_idle", din_ready, 1);
    @(posedge clk);
    #2 rstn = 1'b1;
    idleCycles(2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6_needs_sop", err_sop, 1);
    idleCycles(2);
    checkOutput("t6_eop", n_eop, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
